// File: rtl/uart_link_scheduler_if.sv
// UART line monitors and mux control between the Pi, its peripherals and the link scheduler.
interface uart_link_scheduler_if;
  logic XbeeGpsRequest;
  logic RPITx;
  logic GpsTx;
  logic XbeeTx;
  logic XbeeGpsSelect;
  logic RxMask;
  logic Pending;
  logic SwitchDone;
  logic ForcedSwitch;

  modport master (
    output XbeeGpsRequest, RPITx, GpsTx, XbeeTx,
    input  XbeeGpsSelect, RxMask, Pending, SwitchDone, ForcedSwitch
  );

  modport slave (
    input  XbeeGpsRequest, RPITx, GpsTx, XbeeTx,
    output XbeeGpsSelect, RxMask, Pending, SwitchDone, ForcedSwitch
  );
endinterface

// File: rtl/uart_link_scheduler.sv
// Moves the Pi UART between GPS and Xbee only at an idle frame boundary, then masks Rx for a guard time.
// Optional forced switch after a WAIT_IDLE timeout: define UART_SWITCH_TIMEOUT_EN.
module uart_link_scheduler #(
  parameter int CLKS_PER_BIT = 434,
  parameter int IDLE_BITS    = 12,
  parameter int GUARD_BITS   = 2,
  parameter int TIMEOUT_BITS = 200
) (
  input  logic Clk,
  input  logic ResetN,
  uart_link_scheduler_if.slave link
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(IDLE_BITS + 1);
  localparam int GW = (GUARD_BITS > 1) ? $clog2(GUARD_BITS) : 1;
  localparam logic [BW-1:0] BIT_LAST   = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDLE_MAX   = IW'(IDLE_BITS);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_BITS - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_BITS - 1);

  typedef enum logic [1:0] {LOCKED, WAIT_IDLE, GUARD} stateT;

  stateT         state, stateNext;
  logic [3:0]    syncStage_p0, syncStage_p1;
  logic          reqSync, rpiSync, gpsSync, xbeeSync;
  logic          anyLow, tick, idleDone, guardDone, timeoutDone, stateChange;
  logic [BW-1:0] bitCnt;
  logic [IW-1:0] idleCnt;
  logic [GW-1:0] guardCnt;
  logic          selectQ, maskQ, pendingQ, doneQ;
  logic          selectNext, maskNext, pendingNext, doneNext;

  // Stage p0/p1: two-flop synchronisers, Tx lines reset to idle-high
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      syncStage_p0 <= 4'b0111;
      syncStage_p1 <= 4'b0111;
    end else begin
      syncStage_p0 <= {link.XbeeGpsRequest, link.RPITx, link.GpsTx, link.XbeeTx};
      syncStage_p1 <= syncStage_p0;
    end
  end

  assign {reqSync, rpiSync, gpsSync, xbeeSync} = syncStage_p1;

  // Only the Pi line and the currently selected peripheral gate a switch
  assign anyLow      = !rpiSync || (selectQ ? !xbeeSync : !gpsSync);
  assign tick        = (bitCnt == BIT_LAST);
  assign idleDone    = !anyLow && ((idleCnt == IDLE_MAX) || (tick && idleCnt == IDLE_LAST));
  assign guardDone   = tick && (guardCnt == GUARD_LAST);
  assign stateChange = (stateNext != state);

  always_ff @(posedge Clk) begin
    if (!ResetN || stateChange || anyLow || tick) bitCnt <= '0;
    else                                          bitCnt <= bitCnt + BW'(1);
  end

  always_ff @(posedge Clk) begin
    if (!ResetN || stateChange || anyLow)  idleCnt <= '0;
    else if (tick && idleCnt != IDLE_MAX)  idleCnt <= idleCnt + IW'(1);
  end

  always_ff @(posedge Clk) begin
    if (!ResetN || stateChange)         guardCnt <= '0;
    else if (state == GUARD && tick)    guardCnt <= guardCnt + GW'(1);
  end

`ifdef UART_SWITCH_TIMEOUT_EN
  localparam int TW = (TIMEOUT_BITS > 1) ? $clog2(TIMEOUT_BITS) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_BITS - 1);

  logic [BW-1:0] toBitCnt;
  logic [TW-1:0] toCnt;
  logic          toTick, forcedQ;

  // Free-running bit timer so line activity cannot postpone the timeout
  assign toTick      = (toBitCnt == BIT_LAST);
  assign timeoutDone = (state == WAIT_IDLE) && toTick && (toCnt == TO_LAST);

  always_ff @(posedge Clk) begin
    if (!ResetN || stateChange) begin
      toBitCnt <= '0;
      toCnt    <= '0;
    end else begin
      toBitCnt <= toTick ? '0 : toBitCnt + BW'(1);
      if (toTick && state == WAIT_IDLE) toCnt <= toCnt + TW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!ResetN) forcedQ <= 1'b0;
    else         forcedQ <= (state == WAIT_IDLE) && (stateNext == GUARD) && timeoutDone && !idleDone;
  end

  assign link.ForcedSwitch = forcedQ;
`else
  assign timeoutDone       = 1'b0;
  assign link.ForcedSwitch = 1'b0;
`endif

  always_comb begin
    stateNext  = state;
    selectNext = selectQ;
    doneNext   = 1'b0;
    unique case (state)
      LOCKED: begin
        if (reqSync != selectQ) stateNext = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (reqSync == selectQ) begin
          stateNext = LOCKED;
        end else if (idleDone || timeoutDone) begin
          stateNext  = GUARD;
          selectNext = ~selectQ;
        end
      end
      GUARD: begin
        if (guardDone) begin
          stateNext = LOCKED;
          doneNext  = 1'b1;
        end
      end
      default: stateNext = LOCKED;
    endcase
    maskNext    = (stateNext == GUARD);
    pendingNext = (stateNext != LOCKED);
  end

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state    <= LOCKED;
      selectQ  <= 1'b0;
      maskQ    <= 1'b0;
      pendingQ <= 1'b0;
      doneQ    <= 1'b0;
    end else begin
      state    <= stateNext;
      selectQ  <= selectNext;
      maskQ    <= maskNext;
      pendingQ <= pendingNext;
      doneQ    <= doneNext;
    end
  end

  assign link.XbeeGpsSelect = selectQ;
  assign link.RxMask        = maskQ;
  assign link.Pending       = pendingQ;
  assign link.SwitchDone    = doneQ;
endmodule

// File: doc/uart_link_scheduler.md
# uart_link_scheduler

Controller that decides when the Raspberry Pi's single UART moves between the GPS module and the Xbee radio. The Pi requests a target. The block changes the mux select only at a safe frame boundary: after the Pi line and the active peripheral line have both been idle long enough. It then masks all receive lines through a guard interval. It drives the select and mask inputs of the existing 2-to-1 UART mux in FlightControl, so no partial UART frame is ever spliced onto the wrong device.

## Interface
- CLKS_PER_BIT, default 434: clock cycles per UART bit (50 MHz / 115200 baud).
- IDLE_BITS, default 12: continuous idle bit-times required before a switch.
- GUARD_BITS, default 2: bit-times the Rx mask stays asserted after a switch.
- TIMEOUT_BITS, default 200: bit-times in WAIT_IDLE before a forced switch (used only with the macro below).
- Clk  input  1  system clock; all logic on the rising edge.
- ResetN  input  1  synchronous, active-low reset.
- XbeeGpsRequest  input  1  asynchronous request from the Pi: 1 = Xbee, 0 = GPS.
- RPITx  input  1  asynchronous Pi UART Tx (monitored only).
- GpsTx  input  1  asynchronous GPS UART Tx (monitored only).
- XbeeTx  input  1  asynchronous Xbee UART Tx (monitored only).
- XbeeGpsSelect  output  1  mux select: 1 = Xbee, 0 = GPS.
- RxMask  output  1  1 = the mux must drive every Rx line to idle-high.
- Pending  output  1  a switch is in progress (WAIT_IDLE or GUARD).
- SwitchDone  output  1  one-cycle pulse when a switch completes.
- ForcedSwitch  output  1  one-cycle pulse when a switch was forced by timeout.

## Operation
- **Synchronisers.** All four async inputs pass through a 2-flop synchroniser. The synchroniser reset value is 1 for the Tx lines and 0 for the request.
- **Monitored lines.** RPITx, plus GpsTx when XbeeGpsSelect=0, or XbeeTx when XbeeGpsSelect=1.
- **Bit tick.**
  - Counter runs 0..CLKS_PER_BIT-1; the tick fires on the terminal count.
  - Counter restarts at 0 on every state entry and whenever any monitored line is sampled low.
- **Idle counter.**
  - Counts ticks while all monitored lines are high.
  - Clears to 0 on any low sample.
  - Saturates at IDLE_BITS.
- **State machine:**
  - LOCKED: select stable; the request is ignored while it equals XbeeGpsSelect. Go to WAIT_IDLE when the synchronised request differs from XbeeGpsSelect.
  - WAIT_IDLE: Pending=1.
    - If the synchronised request again equals XbeeGpsSelect, return to LOCKED with no switch and no SwitchDone.
    - When the idle counter reaches IDLE_BITS, toggle XbeeGpsSelect, set RxMask=1 and go to GUARD.
  - GUARD: Pending=1, RxMask=1. Request changes are ignored. After GUARD_BITS ticks, clear RxMask, pulse SwitchDone and go to LOCKED.
- A request changed during GUARD is acted on from LOCKED on the following cycle.
- All counters are sized with $clog2 of their maximum value and never wrap.
- **Reset:** ResetN=0 at any point, including mid-switch, returns to LOCKED on the next edge.

## Timing
- Reset values:
  - XbeeGpsSelect=0, RxMask=0, Pending=0, SwitchDone=0, ForcedSwitch=0.
  - All counters 0.
- All outputs are registered.
- A request edge at an input reaches the FSM after 2 cycles; Pending rises 1 cycle later.
- Minimum switch latency, lines already idle: IDLE_BITS×CLKS_PER_BIT cycles after WAIT_IDLE entry.
  - XbeeGpsSelect and RxMask change on the same edge.
- RxMask stays high for exactly GUARD_BITS×CLKS_PER_BIT cycles.
- SwitchDone pulses on the same edge that RxMask falls; Pending falls on that edge too.
- Simultaneous events in WAIT_IDLE:
  - Request withdrawn on the cycle idle completes: the withdrawal wins and no switch occurs.
  - A low sample on the tick cycle clears the idle counter and blocks the switch.

## Configuration
- **UART_SWITCH_TIMEOUT_EN defined:**
  - WAIT_IDLE counts ticks in its own counter, which is not cleared by line activity.
  - Reaching TIMEOUT_BITS performs the switch exactly as if idle had completed, and ForcedSwitch pulses on the switch edge.
  - Idle completion and timeout on the same cycle counts as a normal switch, with no ForcedSwitch.
- **Not defined:**
  - WAIT_IDLE waits indefinitely for idle.
  - ForcedSwitch is tied to 0, and no timeout counter is synthesised.

## Test plan
Bench parameters: CLKS_PER_BIT=4, IDLE_BITS=3, GUARD_BITS=2, TIMEOUT_BITS=8.
- **Reset:** ResetN=0 for 3 cycles with random inputs → XbeeGpsSelect=0, RxMask=0, Pending=0, no pulses.
- **Clean switch:** all Tx lines high, request 0→1 → Pending high 3 cycles later; XbeeGpsSelect=1 and RxMask=1 12 cycles after Pending rises; RxMask low 8 cycles later with a single SwitchDone pulse.
- **Busy line:** GpsTx pulled low 1 cycle every 10 cycles while the request is 1 →
  - without the macro: select stays 0 for 500 cycles;
  - with the macro: select=1 and a ForcedSwitch pulse 32 cycles after WAIT_IDLE entry.
- **Withdrawal:** request 0→1, then back to 0 after 6 cycles in WAIT_IDLE → Pending falls, select stays 0, no SwitchDone.
- **Request during GUARD:** request toggles back to 0 during GUARD → guard completes with SwitchDone; Pending re-rises the next cycle; the reverse switch completes normally.
- **Reset mid-guard:** ResetN=0 during GUARD → next edge gives select=0, RxMask=0, Pending=0.
